lcd_driver: RTL and testbench

LCD_DRIVER -- requirements
Module: lcd_driver

---
 rtl/lcd_driver_if.sv | 23 ++
 rtl/lcd_driver.sv | 209 ++++++++++++++++++++
 tb/tb_lcd_driver.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_driver_if.sv
// Pin bundle between the HD44780 character-LCD driver and the logic that supplies the frame.
// The driver uses the master view; whatever feeds the frame and watches the pins uses the slave view.
interface lcd_driver_if;
    logic [31:0][7:0] ASCII;
    logic             UpdateLCD;
    logic [7:0]       LCD_DATA;
    logic             LCD_RS;
    logic             LCD_RW;
    logic             LCD_EN;
    logic             LCD_ON;
    logic             Ready;
    logic             Busy;

    modport master (
        input  ASCII, UpdateLCD,
        output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, Ready, Busy
    );

    modport slave (
        output ASCII, UpdateLCD,
        input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, Ready, Busy
    );
endinterface

// File: rtl/lcd_driver.sv
// HD44780 8-bit write-only driver: power-on wait, four-command init, then 2x16 frame refreshes
// triggered by rising edges of UpdateLCD.
module lcd_driver #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned EN_CYC      = 16,
    parameter int unsigned SHORT_WAIT  = 2000,
    parameter int unsigned CLEAR_WAIT  = 82000
) (
    input  logic         clk,
    input  logic         reset,
    lcd_driver_if.master lcd
);

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StIdle,
        StLine1Addr,
        StLine1Chars,
        StLine2Addr,
        StLine2Chars
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             pending_q, pending_d;
    logic             ready_q, ready_d;
    logic             on_q;
    logic             upd_q;
    logic [31:0][7:0] buf_q, buf_d;

    logic             upd_edge;
    logic             sending;
    logic             xfer_done;
    logic             start_xfer;
    logic [31:0]      xfer_last;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        logic [7:0] b;
        unique case (i)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    assign upd_edge = lcd.UpdateLCD & ~upd_q;
    assign sending  = (state_q != StPwrup) && (state_q != StIdle);

    // A transfer spans cycle 0 (setup), EN_CYC strobe cycles, then the settle wait.
    always_comb begin
        if (state_q == StInit && idx_q == 5'd2) begin
            xfer_last = EN_CYC + CLEAR_WAIT;
        end else begin
            xfer_last = EN_CYC + SHORT_WAIT;
        end
    end

    assign xfer_done = (cnt_q == xfer_last);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        buf_d      = buf_q;
        pending_d  = pending_q | upd_edge;
        start_xfer = 1'b0;

        unique case (state_q)
            StPwrup: begin
                if (cnt_q == POWERUP_CYC - 32'd1) begin
                    state_d    = StInit;
                    cnt_d      = '0;
                    idx_d      = '0;
                    start_xfer = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StIdle: begin
                if (pending_q) begin
                    // An edge landing in this very cycle stays pending for the next refresh.
                    pending_d  = upd_edge;
                    buf_d      = lcd.ASCII;
                    state_d    = StLine1Addr;
                    cnt_d      = '0;
                    start_xfer = 1'b1;
                end
            end
            default: begin
                if (!xfer_done) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d      = '0;
                    start_xfer = 1'b1;
                    unique case (state_q)
                        StInit: begin
                            if (idx_q == 5'd3) begin
                                state_d    = StIdle;
                                idx_d      = '0;
                                ready_d    = 1'b1;
                                start_xfer = 1'b0;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                        StLine1Addr: begin
                            state_d = StLine1Chars;
                            idx_d   = 5'd0;
                        end
                        StLine1Chars: begin
                            if (idx_q == 5'd15) begin
                                state_d = StLine2Addr;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                        StLine2Addr: begin
                            state_d = StLine2Chars;
                            idx_d   = 5'd16;
                        end
                        StLine2Chars: begin
                            if (idx_q == 5'd31) begin
                                state_d    = StIdle;
                                idx_d      = '0;
                                start_xfer = 1'b0;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end
                        default: begin
                            state_d    = StPwrup;
                            start_xfer = 1'b0;
                        end
                    endcase
                end
            end
        endcase

        // Bus value is latched at the start of each transfer and held until the next one.
        data_d = data_q;
        rs_d   = rs_q;
        if (start_xfer) begin
            unique case (state_d)
                StInit: begin
                    data_d = init_byte(idx_d[1:0]);
                    rs_d   = 1'b0;
                end
                StLine1Addr: begin
                    data_d = 8'h80;
                    rs_d   = 1'b0;
                end
                StLine2Addr: begin
                    data_d = 8'hC0;
                    rs_d   = 1'b0;
                end
                StLine1Chars, StLine2Chars: begin
                    data_d = buf_d[idx_d];
                    rs_d   = 1'b1;
                end
                default: begin
                    data_d = data_q;
                    rs_d   = rs_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // Tracks the input even in reset so a level held across reset is not seen as an edge.
        upd_q <= lcd.UpdateLCD;
        if (!reset) begin
            state_q   <= StPwrup;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            on_q      <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            on_q      <= 1'b1;
            buf_q     <= buf_d;
        end
    end

    assign lcd.LCD_DATA = data_q;
    assign lcd.LCD_RS   = rs_q;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_EN   = sending && (cnt_q != 32'd0) && (cnt_q <= EN_CYC);
    assign lcd.LCD_ON   = on_q;
    assign lcd.Ready    = ready_q;
    assign lcd.Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_driver.sv
// Randomized scoreboard bench for lcd_driver: expected LCD bytes are queued as stimulus is issued
// and a pin monitor pops and checks them on every enable strobe.
module tb_lcd_driver;
    localparam int PWR = 20;
    localparam int ENC = 2;
    localparam int SW  = 5;
    localparam int CW  = 10;

    typedef logic [31:0][7:0] frame_t;
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         wait_c;
        logic       ready;
        int         idle_exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    lcd_driver_if lcd ();

    lcd_driver #(
        .POWERUP_CYC(PWR),
        .EN_CYC     (ENC),
        .SHORT_WAIT (SW),
        .CLEAR_WAIT (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lcd  (lcd.master)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Pin monitor: decodes strobes, timing gaps and Ready timing.
    exp_t       cur;
    int         rise_cnt = 0;
    int         low_cnt, last_wait, hi_cnt, idle_run;
    bit         in_pulse, busy_drop, stable, busy_hi, prev_ready;
    logic [7:0] cur_data;
    logic       cur_rs;

    always @(negedge clk) begin
        if (!reset) begin
            low_cnt    = 0;
            last_wait  = PWR;
            idle_run   = 0;
            in_pulse   = 1'b0;
            busy_drop  = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (lcd.LCD_EN && !in_pulse) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {23'd0, lcd.LCD_RS, lcd.LCD_DATA}, 32'hFFFF_FFFF);
                    cur.wait_c = SW;
                end else begin
                    cur = exp_q.pop_front();
                    chk("byte_data", lcd.LCD_DATA, cur.data);
                    chk("byte_rs", lcd.LCD_RS, cur.rs);
                    chk("ready_during_byte", lcd.Ready, cur.ready);
                    if (!busy_drop) chk("gap_cycles", low_cnt, last_wait + 1);
                    if (cur.idle_exp >= 0) chk("idle_before_refresh", idle_run, cur.idle_exp);
                end
                in_pulse = 1'b1;
                hi_cnt   = 1;
                stable   = 1'b1;
                busy_hi  = lcd.Busy;
                cur_data = lcd.LCD_DATA;
                cur_rs   = lcd.LCD_RS;
            end else if (lcd.LCD_EN) begin
                hi_cnt++;
                if (lcd.LCD_DATA !== cur_data || lcd.LCD_RS !== cur_rs) stable = 1'b0;
                busy_hi = busy_hi & lcd.Busy;
            end else begin
                if (in_pulse) begin
                    chk("en_width", hi_cnt, ENC);
                    chk("bus_stable_in_strobe", {31'd0, stable}, 32'd1);
                    chk("bus_held_after_strobe", {23'd0, lcd.LCD_RS, lcd.LCD_DATA},
                        {23'd0, cur_rs, cur_data});
                    chk("busy_in_strobe", {31'd0, busy_hi}, 32'd1);
                    in_pulse  = 1'b0;
                    low_cnt   = 0;
                    busy_drop = 1'b0;
                    idle_run  = 0;
                    last_wait = cur.wait_c;
                end
                if (lcd.Ready && !prev_ready) chk("ready_rise_time", low_cnt, last_wait);
                low_cnt++;
                if (!lcd.Busy) begin
                    busy_drop = 1'b1;
                    idle_run++;
                end
            end
            prev_ready = lcd.Ready;
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic rs, input int w, input logic rdy,
                             input int idle_exp);
        exp_t e;
        e.data = d; e.rs = rs; e.wait_c = w; e.ready = rdy; e.idle_exp = idle_exp;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_byte(8'h38, 1'b0, SW, 1'b0, -1);
        push_byte(8'h0C, 1'b0, SW, 1'b0, -1);
        push_byte(8'h01, 1'b0, CW, 1'b0, -1);
        push_byte(8'h06, 1'b0, SW, 1'b0, -1);
    endtask

    // A refresh is the line-1 address, 16 chars, the line-2 address, 16 chars.
    task automatic push_frame(input frame_t f, input int idle_exp);
        push_byte(8'h80, 1'b0, SW, 1'b1, idle_exp);
        for (int i = 0; i < 16; i++) push_byte(f[i], 1'b1, SW, 1'b1, -1);
        push_byte(8'hC0, 1'b0, SW, 1'b1, -1);
        for (int i = 16; i < 32; i++) push_byte(f[i], 1'b1, SW, 1'b1, -1);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < 32; i++) f[i] = 8'($urandom_range(32, 126));
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_update();
        lcd.UpdateLCD = 1'b0;
        step(1);
        lcd.UpdateLCD = 1'b1;
        step(1);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || lcd.Busy) && n < 5000) begin
            step(1);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending bytes expected 0", tag, exp_q.size());
        end
        step(40);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        chk({tag, "_ready"}, lcd.Ready, 1'b1);
        chk({tag, "_busy_idle"}, lcd.Busy, 1'b0);
        chk({tag, "_lcd_on"}, lcd.LCD_ON, 1'b1);
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rise_cnt < target && n < 2000) begin
            step(1);
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL rise_timeout: got %0d strobes expected %0d", rise_cnt, target);
        end
    endtask

    initial begin
        frame_t f;
        string  s;
        int     r0;

        reset         = 1'b0;
        lcd.ASCII     = '0;
        lcd.UpdateLCD = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_en", lcd.LCD_EN, 1'b0);
        chk("rst_on", lcd.LCD_ON, 1'b0);
        chk("rst_ready", lcd.Ready, 1'b0);
        chk("rst_busy", lcd.Busy, 1'b1);
        chk("rst_data", lcd.LCD_DATA, 8'h00);
        chk("rst_rs", lcd.LCD_RS, 1'b0);
        chk("rst_rw", lcd.LCD_RW, 1'b0);
        step(1);
        push_init();
        reset = 1'b1;
        wait_quiet("init");

        // Known score frame.
        s = "PLAYER1 3       PLAYER2 5       ";
        for (int i = 0; i < 32; i++) f[i] = s[i];
        lcd.ASCII = f;
        push_frame(f, -1);
        pulse_update();
        wait_quiet("score_frame");

        // Frame changes and edges mid-refresh collapse into one follow-up refresh.
        f = rand_frame();
        lcd.ASCII = f;
        push_frame(f, -1);
        r0 = rise_cnt;
        pulse_update();
        wait_rises(r0 + 5);
        for (int k = 0; k < 3; k++) begin
            f = rand_frame();
            lcd.ASCII = f;
            pulse_update();
        end
        push_frame(f, -1);
        wait_quiet("collapse");

        // A long high level is a single edge.
        lcd.UpdateLCD = 1'b0;
        step(2);
        f = rand_frame();
        lcd.ASCII = f;
        push_frame(f, -1);
        lcd.UpdateLCD = 1'b1;
        step(100);
        lcd.UpdateLCD = 1'b0;
        wait_quiet("held_level");

        for (int k = 0; k < 4; k++) begin
            step($urandom_range(0, 30));
            f = rand_frame();
            lcd.ASCII = f;
            push_frame(f, -1);
            pulse_update();
            wait_quiet("random_refresh");
        end

        // Reset while character 7 is being strobed.
        f = rand_frame();
        lcd.ASCII = f;
        push_frame(f, -1);
        r0 = rise_cnt;
        pulse_update();
        wait_rises(r0 + 9);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_en", lcd.LCD_EN, 1'b0);
        chk("abort_ready", lcd.Ready, 1'b0);
        chk("abort_on", lcd.LCD_ON, 1'b0);
        step(2);
        push_init();
        reset = 1'b1;
        wait_quiet("reinit");

        // Edge during power-up wait: refresh right after init.
        reset = 1'b0;
        step(3);
        push_init();
        f = rand_frame();
        lcd.ASCII = f;
        push_frame(f, 1);
        reset = 1'b1;
        step(5);
        pulse_update();
        wait_quiet("pwrup_edge");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
